// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared widths, constants and the prefetch entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [ADDR_W-1:0]  PC_STEP   = 32'd4;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_if
// Description : Instruction memory request/grant and in-order response bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic               imem_req_o;
  logic [ADDR_W-1:0]  imem_addr_o;
  logic               imem_gnt_i;
  logic               imem_rvalid_i;
  logic [INSTR_W-1:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous prefetch FIFO of fetch entries with flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  input  wire logic                      i_push,
  input  wire fetch_entry_t              i_data,
  input  wire logic                      i_pop,
  input  wire logic                      i_flush,
  output fetch_entry_t                   o_head,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH):0]         o_count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  fetch_entry_t       r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == c_CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + c_PTR_W'(1);
      if (w_do_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
      r_count <= r_count + c_CNT_W'(w_do_push) - c_CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : PC, credit-limited imem fetch, stale-response drop, prefetch.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                FIFO_DEPTH = 4
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                stall_i,
  input  wire logic                redirect_valid_i,
  input  wire logic [ADDR_W-1:0]   redirect_pc_i,
  instr_fetch_unit_if.master       imem,
  output logic [INSTR_W-1:0]       instr_o,
  output logic [ADDR_W-1:0]        pc_o,
  output logic                     instr_valid_o
);

  localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int c_SUM_W = c_CNT_W + 1;

  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  r_resp_pc;
  logic [c_CNT_W-1:0] r_outstanding;
  logic [c_CNT_W-1:0] r_drop_cnt;

  fetch_entry_t       w_head;
  fetch_entry_t       w_push_data;
  logic [c_CNT_W-1:0] w_count;
  logic [c_CNT_W-1:0] w_outstanding_nxt;
  logic [c_SUM_W-1:0] w_credit_used;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_req;
  logic               w_accept;
  logic               w_resp;
  logic               w_drop;
  logic               w_push;

  assign w_pop = ~w_empty & ~stall_i;

  // Credits cover both in-flight reads and buffered words, so a push never finds the FIFO full.
  assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_count} - c_SUM_W'(w_pop);
  assign w_req    = ~rst & ~redirect_valid_i & (w_credit_used < c_SUM_W'(FIFO_DEPTH));
  assign w_accept = w_req & imem.imem_gnt_i;
  assign w_resp   = imem.imem_rvalid_i & (r_outstanding != '0);
  assign w_drop   = w_resp & (r_drop_cnt != '0);
  assign w_push   = w_resp & ~w_drop & ~redirect_valid_i & ~w_full;

  assign w_outstanding_nxt = r_outstanding + c_CNT_W'(w_accept) - c_CNT_W'(w_resp);
  assign w_push_data       = '{pc: r_resp_pc, instr: imem.imem_rdata_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      if (redirect_valid_i) begin
        r_fetch_pc <= redirect_pc_i & ~32'h3;
        r_resp_pc  <= redirect_pc_i & ~32'h3;
        r_drop_cnt <= w_outstanding_nxt;
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + PC_STEP;
        if (w_push)   r_resp_pc  <= r_resp_pc + PC_STEP;
        if (w_drop)   r_drop_cnt <= r_drop_cnt - c_CNT_W'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (redirect_valid_i),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign imem.imem_req_o  = w_req;
  assign imem.imem_addr_o = r_fetch_pc;
  assign instr_valid_o    = ~w_empty;
  assign instr_o          = w_empty ? NOP_INSTR : w_head.instr;
  assign pc_o             = w_empty ? '0 : w_head.pc;

endmodule
`default_nettype wire
